calendar_ctrl: RTL and testbench

//  Sequencer for the day/month/year counters sharing one read databus. On each midnight tick it

---
 rtl/calendar_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_calendar_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_ctrl.sv
// Calendar sequencer: on each midnight tick it reads day/month/year over a
// shared bus and loads the next date. It also runs the button-driven
// date-set mode (day -> month -> year) and commits the edited values.
module calendar_ctrl #(
   parameter int YEAR_W   = 7,
   parameter int YEAR_MAX = 99
) (
   input  logic                  clk_i,
   input  logic                  clear_i,
   input  logic                  day_tick_i,
   input  logic                  btn_mode_i,
   input  logic                  btn_inc_i,
   input  logic [YEAR_W-1:0]     bus_in_i,
   output logic [2:0]            rd_en_o,
   output logic                  day_ld_o,
   output logic                  month_ld_o,
   output logic                  year_ld_o,
   output logic [3*YEAR_W-1:0]   ld_data_o,
   output logic [1:0]            edit_field_o,
   output logic [YEAR_W-1:0]     edit_val_o
);

   typedef enum logic [3:0] {
      IDLE, RD_D, RD_M, RD_Y, UPD, SET_D, SET_M, SET_Y, COMMIT
   } state_t;

   localparam logic [YEAR_W-1:0] ONE_C  = YEAR_W'(1);
   localparam logic [YEAR_W-1:0] ZERO_C = YEAR_W'(0);
   localparam logic [YEAR_W-1:0] DEC_C  = YEAR_W'(12);
   localparam logic [YEAR_W-1:0] YMAX_C = YEAR_W'(YEAR_MAX);

   // Days in month; February has 29 days whenever the year is a multiple of 4.
   function automatic logic [YEAR_W-1:0] dim_f(input logic [YEAR_W-1:0] m,
                                                input logic [YEAR_W-1:0] y);
      logic [YEAR_W-1:0] r;
      case (m)
         YEAR_W'(4), YEAR_W'(6), YEAR_W'(9), YEAR_W'(11): r = YEAR_W'(30);
         YEAR_W'(2): r = (y[1:0] == 2'b00) ? YEAR_W'(29) : YEAR_W'(28);
         default:    r = YEAR_W'(31);
      endcase
      return r;
   endfunction

   state_t              state_q;
   logic                set_mode_q;
   logic [YEAR_W-1:0]   day_q, month_q, year_q;
   logic [2:0]          rd_en_q;
   logic                day_ld_q, month_ld_q, year_ld_q;
   logic [3*YEAR_W-1:0] ld_data_q;
   logic [1:0]          edit_field_q;
   logic [YEAR_W-1:0]   edit_val_q;

   logic [YEAR_W-1:0]   upd_mon_fix_s, upd_dim_s;
   logic                upd_mon_bad_s;
   logic [YEAR_W-1:0]   day_d, month_d, year_d;
   logic                day_ld_d, month_ld_d, year_ld_d;
   logic [YEAR_W-1:0]   edit_dim_s, inc_day_d, inc_mon_d, inc_yr_d, commit_day_d;

   // Next date for the tick update; the year is taken live from the bus in RD_Y.
   always_comb begin
      if ((month_q == ZERO_C) || (month_q > DEC_C)) begin
         upd_mon_fix_s = ONE_C;
         upd_mon_bad_s = 1'b1;
      end else begin
         upd_mon_fix_s = month_q;
         upd_mon_bad_s = 1'b0;
      end
      upd_dim_s  = dim_f(upd_mon_fix_s, bus_in_i);
      day_d      = day_q;
      month_d    = upd_mon_fix_s;
      year_d     = bus_in_i;
      day_ld_d   = 1'b1;
      month_ld_d = upd_mon_bad_s;
      year_ld_d  = 1'b0;
      if ((day_q == ZERO_C) || (day_q > upd_dim_s)) begin
         day_d = ONE_C;
      end else if (day_q < upd_dim_s) begin
         day_d = day_q + ONE_C;
      end else begin
         day_d      = ONE_C;
         month_ld_d = 1'b1;
         if (upd_mon_fix_s == DEC_C) begin
            month_d   = ONE_C;
            year_ld_d = 1'b1;
            year_d    = (bus_in_i >= YMAX_C) ? ZERO_C : (bus_in_i + ONE_C);
         end else begin
            month_d = upd_mon_fix_s + ONE_C;
         end
      end
   end

   // Field increments and commit clamp used during set mode.
   always_comb begin
      edit_dim_s = dim_f(month_q, year_q);
      inc_day_d  = (day_q >= edit_dim_s) ? ONE_C : (day_q + ONE_C);
      inc_mon_d  = (month_q >= DEC_C) ? ONE_C : (month_q + ONE_C);
      inc_yr_d   = (year_q >= YMAX_C) ? ZERO_C : (year_q + ONE_C);
      if (day_q > edit_dim_s) begin
         commit_day_d = edit_dim_s;
      end else if (day_q == ZERO_C) begin
         commit_day_d = ONE_C;
      end else begin
         commit_day_d = day_q;
      end
   end

   // Sequencer FSM with registered Moore outputs.
   always_ff @(posedge clk_i or posedge clear_i) begin
      if (clear_i) begin
         state_q      <= IDLE;
         set_mode_q   <= 1'b0;
         day_q        <= ONE_C;
         month_q      <= ONE_C;
         year_q       <= ZERO_C;
         rd_en_q      <= 3'b000;
         day_ld_q     <= 1'b0;
         month_ld_q   <= 1'b0;
         year_ld_q    <= 1'b0;
         ld_data_q    <= '0;
         edit_field_q <= 2'b00;
         edit_val_q   <= ZERO_C;
      end else begin
         day_ld_q   <= 1'b0;
         month_ld_q <= 1'b0;
         year_ld_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               rd_en_q <= 3'b000;
               if (day_tick_i) begin
                  state_q    <= RD_D;
                  rd_en_q    <= 3'b001;
                  set_mode_q <= 1'b0;
               end else if (btn_mode_i) begin
                  state_q    <= RD_D;
                  rd_en_q    <= 3'b001;
                  set_mode_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            RD_D: begin
               day_q   <= bus_in_i;
               rd_en_q <= 3'b010;
               state_q <= RD_M;
            end
            RD_M: begin
               month_q <= bus_in_i;
               rd_en_q <= 3'b100;
               state_q <= RD_Y;
            end
            RD_Y: begin
               rd_en_q <= 3'b000;
               if (set_mode_q) begin
                  year_q       <= bus_in_i;
                  state_q      <= SET_D;
                  edit_field_q <= 2'b01;
                  edit_val_q   <= day_q;
               end else begin
                  day_q      <= day_d;
                  month_q    <= month_d;
                  year_q     <= year_d;
                  day_ld_q   <= day_ld_d;
                  month_ld_q <= month_ld_d;
                  year_ld_q  <= year_ld_d;
                  ld_data_q  <= {year_d, month_d, day_d};
                  state_q    <= UPD;
               end
            end
            UPD: begin
               state_q <= IDLE;
            end
            SET_D: begin
               if (btn_mode_i) begin
                  state_q      <= SET_M;
                  edit_field_q <= 2'b10;
                  edit_val_q   <= month_q;
               end else if (btn_inc_i) begin
                  day_q      <= inc_day_d;
                  edit_val_q <= inc_day_d;
               end else begin
                  state_q <= SET_D;
               end
            end
            SET_M: begin
               if (btn_mode_i) begin
                  state_q      <= SET_Y;
                  edit_field_q <= 2'b11;
                  edit_val_q   <= year_q;
               end else if (btn_inc_i) begin
                  month_q    <= inc_mon_d;
                  edit_val_q <= inc_mon_d;
               end else begin
                  state_q <= SET_M;
               end
            end
            SET_Y: begin
               if (btn_mode_i) begin
                  state_q      <= COMMIT;
                  day_q        <= commit_day_d;
                  day_ld_q     <= 1'b1;
                  month_ld_q   <= 1'b1;
                  year_ld_q    <= 1'b1;
                  ld_data_q    <= {year_q, month_q, commit_day_d};
                  edit_field_q <= 2'b00;
                  edit_val_q   <= ZERO_C;
               end else if (btn_inc_i) begin
                  year_q     <= inc_yr_d;
                  edit_val_q <= inc_yr_d;
               end else begin
                  state_q <= SET_Y;
               end
            end
            COMMIT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q      <= IDLE;
               rd_en_q      <= 3'b000;
               edit_field_q <= 2'b00;
               edit_val_q   <= ZERO_C;
            end
         endcase
      end
   end

   assign rd_en_o      = rd_en_q;
   assign day_ld_o     = day_ld_q;
   assign month_ld_o   = month_ld_q;
   assign year_ld_o    = year_ld_q;
   assign ld_data_o    = ld_data_q;
   assign edit_field_o = edit_field_q;
   assign edit_val_o   = edit_val_q;

endmodule

// File: tb/tb_calendar_ctrl.sv
// Bench for calendar_ctrl: models the day/month/year counters on the shared
// bus, predicts every load from calendar arithmetic and scoreboards it.
module tb_calendar_ctrl;
   localparam int YW = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clear, day_tick, btn_mode, btn_inc;
   logic [YW-1:0]   bus_in;
   logic [2:0]      rd_en;
   logic            day_ld, month_ld, year_ld;
   logic [3*YW-1:0] ld_data;
   logic [1:0]      edit_field;
   logic [YW-1:0]   edit_val;

   calendar_ctrl #(.YEAR_W(YW), .YEAR_MAX(99)) dut (
      .clk_i(clk), .clear_i(clear), .day_tick_i(day_tick), .btn_mode_i(btn_mode),
      .btn_inc_i(btn_inc), .bus_in_i(bus_in), .rd_en_o(rd_en), .day_ld_o(day_ld),
      .month_ld_o(month_ld), .year_ld_o(year_ld), .ld_data_o(ld_data),
      .edit_field_o(edit_field), .edit_val_o(edit_val)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit dl, ml, yl;
      int d, m, y;
   } exp_t;
   exp_t q[$];

   // Counter environment
   int cnt_d, cnt_m, cnt_y;
   int pre_d, pre_m, pre_y;
   bit preset_en = 1'b0;

   always @(posedge clk) begin
      if (preset_en) begin
         cnt_d <= pre_d; cnt_m <= pre_m; cnt_y <= pre_y;
      end else begin
         if (day_ld)   cnt_d <= int'(ld_data[YW-1:0]);
         if (month_ld) cnt_m <= int'(ld_data[2*YW-1:YW]);
         if (year_ld)  cnt_y <= int'(ld_data[3*YW-1:2*YW]);
      end
   end

   assign bus_in = (rd_en == 3'b001) ? YW'(cnt_d) :
                   (rd_en == 3'b010) ? YW'(cnt_m) :
                   (rd_en == 3'b100) ? YW'(cnt_y) : YW'(0);

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int dim(input int m, input int y);
      if (m == 2) return (y % 4 == 0) ? 29 : 28;
      else if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      else return 31;
   endfunction

   // Monitor: every load strobe cycle must match the oldest expectation
   always @(negedge clk) begin
      if (day_ld || month_ld || year_ld) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: got ld=%b%b%b data=%0d/%0d/%0d expected no load",
                     year_ld, month_ld, day_ld, ld_data[YW-1:0], ld_data[2*YW-1:YW],
                     ld_data[3*YW-1:2*YW]);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("day_ld", int'(day_ld), int'(e.dl));
            chk("month_ld", int'(month_ld), int'(e.ml));
            chk("year_ld", int'(year_ld), int'(e.yl));
            chk("ld_day", int'(ld_data[YW-1:0]), e.d);
            chk("ld_month", int'(ld_data[2*YW-1:YW]), e.m);
            chk("ld_year", int'(ld_data[3*YW-1:2*YW]), e.y);
         end
      end
   end

   task automatic preset(input int d, input int m, input int y);
      pre_d = d; pre_m = m; pre_y = y; preset_en = 1'b1;
      @(negedge clk);
      preset_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic press(input bit m, input bit i, input bit t);
      btn_mode = m; btn_inc = i; day_tick = t;
      @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0; day_tick = 1'b0;
   endtask

   // Midnight tick with the expected next date queued first
   task automatic run_tick(input bit check_rd, input bit with_mode);
      exp_t e;
      int d, m, y;
      d = cnt_d + 1; m = cnt_m; y = cnt_y;
      if (d > dim(m, y)) begin
         d = 1; m = m + 1;
         if (m > 12) begin
            m = 1; y = (y + 1 > 99) ? 0 : y + 1;
         end
      end
      e.d = d; e.m = m; e.y = y;
      e.dl = 1'b1; e.ml = (m != cnt_m); e.yl = (y != cnt_y);
      q.push_back(e);
      press(with_mode, 1'b0, 1'b1);
      if (check_rd) begin
         chk("rd_en_c1", int'(rd_en), 1);
         @(negedge clk); chk("rd_en_c2", int'(rd_en), 2);
         @(negedge clk); chk("rd_en_c3", int'(rd_en), 4);
         @(negedge clk); chk("rd_en_c4", int'(rd_en), 0);
      end else begin
         repeat (3) @(negedge clk);
      end
      if (with_mode) chk("no_set_after_tick", int'(edit_field), 0);
      repeat (2) @(negedge clk);
   endtask

   // Full set-mode session against a model of the edited date
   task automatic set_session(input int nd, input int nm, input int ny,
                              input bit coincide, input bit tick_in_m);
      int d, m, y;
      exp_t e;
      d = cnt_d; m = cnt_m; y = cnt_y;
      press(1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("field_day", int'(edit_field), 1);
      chk("val_day", int'(edit_val), d);
      for (int k = 0; k < nd; k++) begin
         press(1'b0, 1'b1, 1'b0);
         d = (d >= dim(m, y)) ? 1 : d + 1;
         chk("inc_day", int'(edit_val), d);
      end
      press(1'b1, coincide, 1'b0);
      chk("field_month", int'(edit_field), 2);
      chk("val_month", int'(edit_val), m);
      if (tick_in_m) begin
         press(1'b0, 1'b0, 1'b1);
         repeat (5) @(negedge clk);
         chk("tick_in_setm_field", int'(edit_field), 2);
      end
      for (int k = 0; k < nm; k++) begin
         press(1'b0, 1'b1, 1'b0);
         m = (m >= 12) ? 1 : m + 1;
         chk("inc_month", int'(edit_val), m);
      end
      press(1'b1, 1'b0, 1'b0);
      chk("field_year", int'(edit_field), 3);
      chk("val_year", int'(edit_val), y);
      for (int k = 0; k < ny; k++) begin
         press(1'b0, 1'b1, 1'b0);
         y = (y >= 99) ? 0 : y + 1;
         chk("inc_year", int'(edit_val), y);
      end
      if (d > dim(m, y)) d = dim(m, y);
      e.dl = 1'b1; e.ml = 1'b1; e.yl = 1'b1; e.d = d; e.m = m; e.y = y;
      q.push_back(e);
      press(1'b1, 1'b0, 1'b0);
      chk("field_commit", int'(edit_field), 0);
      chk("val_commit", int'(edit_val), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int d, m, y;
      clear = 1'b1; day_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      preset(14, 6, 25);
      chk("rst_rd_en", int'(rd_en), 0);
      chk("rst_loads", int'({year_ld, month_ld, day_ld}), 0);
      chk("rst_ld_data", int'(ld_data), 0);
      chk("rst_edit_field", int'(edit_field), 0);
      chk("rst_edit_val", int'(edit_val), 0);
      clear = 1'b0;
      @(negedge clk);

      // Abort mid-read: no load may follow
      press(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("pre_abort_rd_en", int'(rd_en), 2);
      clear = 1'b1;
      #1;
      chk("abort_rd_en", int'(rd_en), 0);
      chk("abort_loads", int'({year_ld, month_ld, day_ld}), 0);
      chk("abort_ld_data", int'(ld_data), 0);
      @(negedge clk);
      clear = 1'b0;
      repeat (6) @(negedge clk);

      run_tick(1'b1, 1'b0);          // 14/6/25 -> 15
      preset(28, 2, 24); run_tick(1'b0, 1'b0);
      preset(28, 2, 23); run_tick(1'b0, 1'b0);
      preset(31, 12, 99); run_tick(1'b1, 1'b0);
      preset(30, 4, 50); run_tick(1'b0, 1'b1);   // tick + mode together

      for (int i = 0; i < 20; i++) begin
         y = $urandom_range(0, 99);
         m = $urandom_range(1, 12);
         d = ($urandom_range(0, 1) == 1) ? dim(m, y) : $urandom_range(1, dim(m, y));
         preset(d, m, y);
         run_tick(1'b0, 1'b0);
      end

      preset(31, 1, 23); set_session(0, 1, 0, 1'b0, 1'b0);
      preset(20, 3, 40); set_session(2, 0, 1, 1'b1, 1'b1);
      preset(10, 5, 98); set_session(1, 9, 3, 1'b0, 1'b0);
      preset(29, 2, 24); set_session(2, 0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         y = $urandom_range(0, 99);
         m = $urandom_range(1, 12);
         d = $urandom_range(1, dim(m, y));
         preset(d, m, y);
         set_session($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'b0, 1'b0);
      end
      preset(3, 3, 3); run_tick(1'b0, 1'b0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
